tdm_tx_sched: RTL and testbench
===============================

// Module: tdm_tx_sched
// PURPOSE
//  TDM transmit frame scheduler on bit clock. Owns frame timing: one-bclk wclk frame pulse, serial
//  slot data on tdm_out. Per-channel samples enter a double buffer; swap to active set at frame start.
//  Replaces fixed-pattern TDM generator; sits between audio sample sources and the TDM pin.
// PARAMETERS
//  CH         8   number of TDM slots/channels per frame (>=2)
//  SLOT_BITS  32  bits per slot; sample width
// PORTS
//  bclk          in   1               bit clock; all logic on rising edge
//  rst_n         in   1               synchronous reset, active-low
//  run           in   1               1 = transmit frames; 0 = stop at end of current frame
//  slot_en       in   CH              per-slot enable; disabled slot transmits all zeros
//  wr_en         in   1               write strobe into shadow buffer
//  wr_ch         in   $clog2(CH)      target channel; wr_ch>=CH ignored
//  wr_data       in   SLOT_BITS       sample for next frame
//  underrun_clr  in   1               clear sticky underrun
//  wclk          out  1               frame sync, high one bclk at slot 0 bit 0
//  tdm_out       out  1               serial data, MSB first, slot 0 first
//  busy          out  1               state != IDLE
//  underrun      out  1               sticky: enabled slot not written before frame swap
// BEHAVIOUR
//  - Reset: state IDLE, wclk=0, tdm_out=0, busy=0, underrun=0, counters=0, shadow/active/written=0.
//  - Counters: bit_cnt 0..SLOT_BITS-1, slot_cnt 0..CH-1; bit_cnt wraps to 0 and increments slot_cnt;
//    slot_cnt wraps CH-1 -> 0 = frame end. Outputs registered, change on rising bclk only.
//  - FSM: IDLE --run=1--> RUN; RUN --run=0--> STOP; STOP --run=1--> RUN (no gap);
//    STOP --last bit of slot CH-1 sent--> IDLE. RUN at frame end rolls straight into next frame.
//  - Frame start (IDLE->RUN edge, or frame end while RUN): active <= shadow, written <= 0,
//    wclk=1 that cycle; slot 0 MSB driven same cycle (see CONFIGURATION). wclk=0 otherwise.
//  - tdm_out = slot_en[slot_cnt] ? active[slot_cnt][SLOT_BITS-1-bit_cnt] : 0. slot_en sampled per bit.
//  - Writes: shadow[wr_ch] <= wr_data, written[wr_ch] <= 1. Write on swap edge: swap copies pre-write
//    shadow; write lands in shadow and counts for the following frame. Multiple writes: last wins.
//  - Underrun: at swap, if any (slot_en & ~written) bit set (pre-write view), underrun <= 1. First swap
//    after reset also flags if any slot enabled. Set and underrun_clr same edge: set wins.
//  - IDLE: wclk=0, tdm_out=0, counters held at 0; shadow writes still accepted.
//  - Reset mid-frame: immediate return to reset state; no partial frame completion.
// CONFIGURATION
//  - TDM_DELAY1_EN defined: data delayed one bclk relative to wclk (I2S-style). Slot 0 MSB appears the
//    cycle after wclk; last LSB of slot CH-1 overlaps next frame's wclk; after STOP, one extra cycle
//    drives final LSB before tdm_out returns to 0; busy stays 1 through that cycle.
//  - Undefined: zero-delay; slot 0 MSB driven in the wclk cycle; IDLE entered immediately after last bit.
// TESTING
//  1 Reset: rst_n=0 with run=1 -> wclk=0,tdm_out=0,busy=0,underrun=0; release -> first wclk next edge.
//  2 Write ch0..7 = 32'hABCD0000+ch, slot_en=8'hFF, run=1 -> wclk period 256 bclk; tdm_out bitstream
//    equals concatenated words MSB first; underrun stays 0 when all rewritten every frame.
//  3 slot_en=8'h05, write only ch0,ch2 -> slots 1,3..7 all zeros; underrun=0; then skip ch2 write ->
//    underrun=1 at next wclk; underrun_clr pulse -> 0; clr on swap edge with miss -> stays 1.
//  4 Write ch3 on exact wclk edge -> current frame slot 3 carries old shadow, next frame carries new.
//  5 Drop run mid-slot 4 -> frame completes, busy falls after slot 7 LSB, no further wclk; reassert
//    run during STOP -> next wclk exactly 256 bclk after previous one.
//  6 Build with TDM_DELAY1_EN: same as 2 -> stream shifted +1 bclk vs wclk; stop adds one busy cycle.

Source files
------------

// File: rtl/tdm_tx_sched.sv
// tdm_tx_sched: TDM transmit frame scheduler running on the bit clock.
// Generates a one-bclk wclk frame pulse and shifts per-channel samples out
// MSB first, slot 0 first. Samples are written into a shadow buffer and
// copied to the active buffer at each frame start.
// Optional build macro TDM_DELAY1_EN: data lags wclk by one bclk (I2S-style).
module tdm_tx_sched #(
    parameter int CH        = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic                    bclk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [CH-1:0]           slot_en,
    input  logic                    wr_en,
    input  logic [$clog2(CH)-1:0]   wr_ch,
    input  logic [SLOT_BITS-1:0]    wr_data,
    input  logic                    underrun_clr,
    output logic                    wclk,
    output logic                    tdm_out,
    output logic                    busy,
    output logic                    underrun
);

    localparam int CW = $clog2(CH);
    localparam int BW = $clog2(SLOT_BITS);
    localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;
`ifdef TDM_DELAY1_EN
    localparam logic [1:0] TAIL = 2'd3;
`endif

    logic [1:0]           state, nxt_state;
    logic [BW-1:0]        bit_cnt, nxt_bit;
    logic [CW-1:0]        slot_cnt, nxt_slot;
    logic [SLOT_BITS-1:0] shadow [CH];
    logic [SLOT_BITS-1:0] active [CH];
    logic [CH-1:0]        written;
    logic [CH-1:0]        wr_mask;
    logic                 wr_ok;
    logic                 swap;
    logic                 nxt_data;
    logic [SLOT_BITS-1:0] src_word;
    logic [BW-1:0]        bit_idx;
`ifdef TDM_DELAY1_EN
    logic                 data_q;
`endif

    // Channel numbers beyond CH are silently dropped.
    assign wr_ok = ({1'b0, wr_ch} < CH_LIM);
    assign busy  = (state != IDLE);

    // One-hot mask of the channel being written this cycle.
    always_comb begin
        wr_mask = '0;
        if (wr_en && wr_ok) begin
            wr_mask[wr_ch] = 1'b1;
        end
    end

    // Next-state, counter advance and frame-start (swap) decision.
    always_comb begin
        swap      = 1'b0;
        nxt_state = state;
        nxt_bit   = bit_cnt;
        nxt_slot  = slot_cnt;
        case (state)
            RUN, STOP: begin
                if (bit_cnt == BW'(SLOT_BITS-1)) begin
                    nxt_bit = '0;
                    if (slot_cnt == CW'(CH-1)) begin
                        nxt_slot = '0;
                        if (run) begin
                            swap      = 1'b1;
                            nxt_state = RUN;
                        end else begin
`ifdef TDM_DELAY1_EN
                            nxt_state = TAIL;
`else
                            nxt_state = IDLE;
`endif
                        end
                    end else begin
                        nxt_slot  = slot_cnt + CW'(1);
                        nxt_state = run ? RUN : STOP;
                    end
                end else begin
                    nxt_bit   = bit_cnt + BW'(1);
                    nxt_state = run ? RUN : STOP;
                end
            end
            default: begin
                nxt_bit  = '0;
                nxt_slot = '0;
                if (run) begin
                    swap      = 1'b1;
                    nxt_state = RUN;
                end else begin
                    nxt_state = IDLE;
                end
            end
        endcase
    end

    // Select the bit to drive next; at a swap the new frame reads the shadow copy directly.
    always_comb begin
        src_word = swap ? shadow[nxt_slot] : active[nxt_slot];
        bit_idx  = BW'(SLOT_BITS-1) - nxt_bit;
        nxt_data = (nxt_state == RUN || nxt_state == STOP) && slot_en[nxt_slot] && src_word[bit_idx];
    end

    // FSM, counters and registered serial outputs.
    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            wclk     <= 1'b0;
            tdm_out  <= 1'b0;
`ifdef TDM_DELAY1_EN
            data_q   <= 1'b0;
`endif
        end else begin
            state    <= nxt_state;
            bit_cnt  <= nxt_bit;
            slot_cnt <= nxt_slot;
            wclk     <= swap;
`ifdef TDM_DELAY1_EN
            data_q   <= nxt_data;
            tdm_out  <= data_q;
`else
            tdm_out  <= nxt_data;
`endif
        end
    end

    // Double buffer: active takes the pre-write shadow at swap; writes always land in shadow.
    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (swap) begin
                for (int i = 0; i < CH; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_en && wr_ok) begin
                shadow[wr_ch] <= wr_data;
            end
        end
    end

    // Written flags and sticky underrun; a set on the swap edge beats a clear.
    always_ff @(posedge bclk) begin
        if (!rst_n) begin
            written  <= '0;
            underrun <= 1'b0;
        end else begin
            written <= (swap ? '0 : written) | wr_mask;
            if (swap && |(slot_en & ~written)) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_tx_sched.sv
// tb_tdm_tx_sched: directed bench for tdm_tx_sched. A frame table drives
// writes, slot enables and underrun clears; the serial stream is logged on
// the falling edge and compared per slot word against a shadow/active model.
// Honours TDM_DELAY1_EN when the design is built with it.
module tb_tdm_tx_sched;

`ifdef TDM_DELAY1_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif
    localparam int LOGN = 8192;

    logic        bclk;
    logic        rst_n;
    logic        run;
    logic [7:0]  slot_en;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [31:0] wr_data;
    logic        underrun_clr;
    logic        wclk;
    logic        tdm_out;
    logic        busy;
    logic        underrun;

    tdm_tx_sched #(.CH(8), .SLOT_BITS(32)) dut (
        .bclk(bclk), .rst_n(rst_n), .run(run), .slot_en(slot_en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .underrun_clr(underrun_clr),
        .wclk(wclk), .tdm_out(tdm_out), .busy(busy), .underrun(underrun)
    );

    typedef struct {
        logic [7:0] en;
        logic [7:0] wmask;
        logic       clr_mid;
        logic       clr_at_swap;
        logic       swap_wr;
        logic       exp_ur_wclk;
        logic       exp_ur_end;
    } row_t;

    row_t        rows [11];
    logic [31:0] shadow_m [8];
    logic [31:0] active_m [8];
    logic [31:0] exp_words [12][8];
    int          ws [12];
    logic        wclk_log [LOGN];
    logic        tdm_log [LOGN];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    // Log outputs on the falling edge, one entry per bit period.
    always @(negedge bclk) begin
        if (cyc < LOGN) begin
            wclk_log[cyc] = wclk;
            tdm_log[cyc]  = tdm_out;
        end
        cyc++;
    end

    // Hard time limit in case the run stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] ch, input logic [31:0] d, input logic clr);
        wr_en        = we;
        wr_ch        = ch;
        wr_data      = d;
        underrun_clr = clr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] getWord(input int idx);
        logic [31:0] w = 'x;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], ((idx + i) < LOGN && (idx + i) >= 0) ? tdm_log[idx + i] : 1'bx};
        end
        return w;
    endfunction

    function automatic int countWclk(input int from, input int len);
        int n = 0;
        for (int i = from; i < from + len; i++) begin
            if (i < LOGN && wclk_log[i] === 1'b1) n++;
        end
        return n;
    endfunction

    // Latch the model's active set from shadow and record expected words for frame f.
    task automatic modelSwap(input int f, input logic [7:0] en);
        for (int s = 0; s < 8; s++) begin
            active_m[s]     = shadow_m[s];
            exp_words[f][s] = en[s] ? active_m[s] : 32'h0;
        end
    endtask

    // Run one table row as a full frame, starting just after its wclk edge.
    task automatic runRow(input int r);
        row_t v = rows[r];
        row_t n = rows[r+1];
        logic [31:0] d;
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0);
        ws[r] = cyc;
        checkOutput($sformatf("wclk_row%0d", r), {31'b0, wclk}, 32'd1);
        checkOutput($sformatf("underrun_swap_row%0d", r), {31'b0, underrun}, {31'b0, v.exp_ur_wclk});
        for (int p = 1; p < 256; p++) begin
            tick();
            applyStimulus(1'b0, 3'd0, 32'h0, 1'b0);
            if (p >= 10 && p < 18 && v.wmask[p-10]) begin
                d = 32'hABCD0000 + ((r + 1) << 12) + (p - 10);
                applyStimulus(1'b1, 3'(p - 10), d, 1'b0);
                shadow_m[p-10] = d;
            end
            if (p == 40 && v.clr_mid) applyStimulus(1'b0, 3'd0, 32'h0, 1'b1);
            if (p == 250) begin
                checkOutput($sformatf("underrun_end_row%0d", r), {31'b0, underrun}, {31'b0, v.exp_ur_end});
            end
            if (p == 255) begin
                slot_en = n.en;
                modelSwap(r + 1, n.en);
                if (v.swap_wr) begin
                    applyStimulus(1'b1, 3'd3, 32'h3C3C5A5A, v.clr_at_swap);
                    shadow_m[3] = 32'h3C3C5A5A;
                end else begin
                    applyStimulus(1'b0, 3'd0, 32'h0, v.clr_at_swap);
                end
            end
        end
        tick();
    endtask

    initial begin
        //            en      wmask   clrM  clrS  swWr  urSwap urEnd
        rows[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[1]  = '{8'hFF, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[2]  = '{8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[3]  = '{8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[4]  = '{8'h05, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rows[5]  = '{8'h05, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rows[6]  = '{8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rows[7]  = '{8'h05, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rows[8]  = '{8'hFF, 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[9]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        rows[10] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with run=1: everything stays quiet.
        rst_n = 1'b0; run = 1'b1; slot_en = 8'h00;
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0);
        advance(3);
        checkOutput("reset_wclk", {31'b0, wclk}, 32'd0);
        checkOutput("reset_tdm", {31'b0, tdm_out}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_underrun", {31'b0, underrun}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("release_wclk", {31'b0, wclk}, 32'd1);
        checkOutput("release_busy", {31'b0, busy}, 32'd1);
        checkOutput("release_underrun_noslots", {31'b0, underrun}, 32'd0);
        run = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Preload all channels in IDLE, then start the frame table.
        slot_en = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 3'(c), 32'hABCD0000 + c, 1'b0);
            shadow_m[c] = 32'hABCD0000 + c;
            tick();
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        modelSwap(0, 8'hFF);
        run = 1'b1;
        tick();
        for (int r = 0; r < 10; r++) runRow(r);

        // Drop run mid slot 4: frame completes, then idle.
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0);
        ws[10] = cyc;
        checkOutput("f10_wclk", {31'b0, wclk}, 32'd1);
        checkOutput("f10_underrun", {31'b0, underrun}, 32'd0);
        advance(133);
        run = 1'b0;
        advance(122);
        checkOutput("stop_busy_last_bit", {31'b0, busy}, 32'd1);
        advance(1);
        checkOutput("stop_wclk_after", {31'b0, wclk}, 32'd0);
        checkOutput("stop_busy_after", {31'b0, busy}, 32'(DLY));
        checkOutput("stop_tdm_after", {31'b0, tdm_out}, {31'b0, (DLY == 1) ? exp_words[10][7][0] : 1'b0});
        advance(1);
        checkOutput("stop_busy_final", {31'b0, busy}, 32'd0);
        checkOutput("stop_tdm_final", {31'b0, tdm_out}, 32'd0);
        advance(8);
        checkOutput("idle_no_wclk", {31'b0, wclk}, 32'd0);

        // Restart, then stop and resume within one frame: period stays 256.
        run = 1'b1;
        tick();
        ws[11] = cyc;
        modelSwap(11, 8'hFF);
        checkOutput("f11_wclk", {31'b0, wclk}, 32'd1);
        checkOutput("f11_underrun_nowrites", {31'b0, underrun}, 32'd1);
        advance(100);
        run = 1'b0;
        advance(50);
        run = 1'b1;
        advance(50);
        checkOutput("stop_resume_busy", {31'b0, busy}, 32'd1);
        advance(56);
        checkOutput("resume_period_wclk", {31'b0, wclk}, 32'd1);
        run = 1'b0;
        advance(256 + DLY + 4);
        checkOutput("f12_end_busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0);
        checkOutput("underrun_clr", {31'b0, underrun}, 32'd0);

        // Reset in the middle of a frame.
        run = 1'b1;
        advance(61);
        checkOutput("pre_reset_busy", {31'b0, busy}, 32'd1);
        checkOutput("pre_reset_underrun", {31'b0, underrun}, 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("midreset_wclk", {31'b0, wclk}, 32'd0);
        checkOutput("midreset_tdm", {31'b0, tdm_out}, 32'd0);
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_underrun", {31'b0, underrun}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("postreset_wclk", {31'b0, wclk}, 32'd1);
        checkOutput("postreset_underrun", {31'b0, underrun}, 32'd1);
        advance(40);
        checkOutput("postreset_tdm_zero", {31'b0, tdm_out}, 32'd0);
        run = 1'b0;
        advance(300);

        // Stream and frame-pulse checks from the log.
        for (int f = 0; f < 12; f++) begin
            checkOutput($sformatf("log_wclk_f%0d", f), {31'b0, wclk_log[ws[f]]}, 32'd1);
            checkOutput($sformatf("log_wclk_gap_f%0d", f), 32'(countWclk(ws[f] + 1, 255)), 32'd0);
            for (int s = 0; s < 8; s++) begin
                checkOutput($sformatf("word_f%0d_s%0d", f, s), getWord(ws[f] + DLY + s * 32), exp_words[f][s]);
            end
        end
        checkOutput("idle_gap_after_f10", 32'(countWclk(ws[10] + 1, ws[11] - ws[10] - 1)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
